// File: rtl/uvmt_axis_st_stream_chkr_pkg.sv
// Shared types for the AXI-Stream end-to-end checker: error codes and stall FSM states.
package uvmt_axis_st_stream_chkr_pkg;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_MISMATCH  = 3'd1,
      ERR_OVERFLOW  = 3'd2,
      ERR_UNDERFLOW = 3'd3,
      ERR_STALL     = 3'd4,
      ERR_PROTOCOL  = 3'd5
   } err_code_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      STALLED
   } stall_state_e;

endpackage

// File: rtl/uvmt_axis_st_stream_chkr_fifo.sv
// Expected-beat FIFO for the stream checker: registered occupancy, combinational head.
module uvmt_axis_st_stream_chkr_fifo #(
   parameter int unsigned WIDTH = 73,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;

   // A push into a full FIFO is only issued alongside a pop; the write lands in the slot being freed.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_level == FULL_LVL);
   assign o_empty = (r_level == '0);
   assign o_level = r_level;

endmodule

// File: rtl/uvmt_axis_st_stream_chkr.sv
// Passive AXI-Stream scoreboard: ingress beats queued, egress beats compared against the head.
// Define UVMT_AXIS_ST_CHKR_PROTOCOL_EN to build valid/payload stability checking on both interfaces.
module uvmt_axis_st_stream_chkr
   import uvmt_axis_st_stream_chkr_pkg::*;
#(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ing_tvalid,
   input  logic                       ing_tready,
   input  logic [DATA_W-1:0]          ing_tdata,
   input  logic [DATA_W/8-1:0]        ing_tkeep,
   input  logic                       ing_tlast,
   input  logic                       egr_tvalid,
   input  logic                       egr_tready,
   input  logic [DATA_W-1:0]          egr_tdata,
   input  logic [DATA_W/8-1:0]        egr_tkeep,
   input  logic                       egr_tlast,
   output logic                       err_pulse,
   output err_code_e                  err_code,
   output logic                       err_sticky,
   output logic [CNT_W-1:0]           beat_cnt,
   output logic [CNT_W-1:0]           pkt_cnt,
   output logic [CNT_W-1:0]           err_cnt,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int unsigned KEEP_W = DATA_W / 8;
   localparam int unsigned ENT_W  = DATA_W + KEEP_W + 1;
   localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic              w_ing_hs, w_egr_hs, w_bypass, w_overflow, w_underflow;
   logic              w_push, w_pop, w_compare, w_mismatch, w_protocol, w_stall;
   logic              w_fifo_full, w_fifo_empty;
   logic [ENT_W-1:0]  w_head, w_exp;
   logic [DATA_W-1:0] w_exp_data;
   logic [KEEP_W-1:0] w_exp_keep;
   logic              w_exp_last;
   err_code_e         w_err;

   logic              r_err_pulse, r_err_sticky;
   err_code_e         r_err_code;
   logic [CNT_W-1:0]  r_beat_cnt, r_pkt_cnt, r_err_cnt;

   stall_state_e      r_state, w_state_nxt;
   logic [TMR_W-1:0]  r_timer, w_timer_nxt;

   assign w_ing_hs    = ing_tvalid & ing_tready;
   assign w_egr_hs    = egr_tvalid & egr_tready;
   assign w_bypass    = w_fifo_empty & w_ing_hs & w_egr_hs;
   assign w_overflow  = w_ing_hs & w_fifo_full & ~w_egr_hs;
   assign w_underflow = w_egr_hs & w_fifo_empty & ~w_ing_hs;
   assign w_push      = w_ing_hs & ~w_bypass & ~w_overflow;
   assign w_pop       = w_egr_hs & ~w_fifo_empty;
   assign w_compare   = w_egr_hs & ~w_underflow;

   uvmt_axis_st_stream_chkr_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  ({ing_tdata, ing_tkeep, ing_tlast}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   // An empty FIFO means the only possible reference is the same-cycle ingress beat.
   assign w_exp = w_fifo_empty ? {ing_tdata, ing_tkeep, ing_tlast} : w_head;
   assign {w_exp_data, w_exp_keep, w_exp_last} = w_exp;

   always_comb begin
      w_mismatch = (egr_tkeep != w_exp_keep) | (egr_tlast != w_exp_last);
      for (int unsigned b = 0; b < KEEP_W; b++) begin
         if (w_exp_keep[b] && (egr_tdata[8*b +: 8] != w_exp_data[8*b +: 8])) w_mismatch = 1'b1;
      end
   end

`ifdef UVMT_AXIS_ST_CHKR_PROTOCOL_EN
   logic             r_ing_hold, r_egr_hold;
   logic [ENT_W-1:0] r_ing_pl, r_egr_pl;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ing_hold <= 1'b0;
         r_egr_hold <= 1'b0;
      end else begin
         r_ing_hold <= ing_tvalid & ~ing_tready;
         r_egr_hold <= egr_tvalid & ~egr_tready;
         r_ing_pl   <= {ing_tdata, ing_tkeep, ing_tlast};
         r_egr_pl   <= {egr_tdata, egr_tkeep, egr_tlast};
      end
   end

   assign w_protocol = (r_ing_hold & (~ing_tvalid | ({ing_tdata, ing_tkeep, ing_tlast} != r_ing_pl)))
                     | (r_egr_hold & (~egr_tvalid | ({egr_tdata, egr_tkeep, egr_tlast} != r_egr_pl)));
`else
   assign w_protocol = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_stall     = 1'b0;
      if ((TIMEOUT == 0) || w_fifo_empty) begin
         w_state_nxt = IDLE;
         w_timer_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = WAIT;
               w_timer_nxt = '0;
            end
            WAIT: begin
               if (w_egr_hs) begin
                  w_timer_nxt = '0;
               end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                  w_state_nxt = STALLED;
                  w_timer_nxt = '0;
                  w_stall     = 1'b1;
               end else begin
                  w_timer_nxt = r_timer + TMR_W'(1);
               end
            end
            STALLED: begin
               if (w_egr_hs) begin
                  w_state_nxt = WAIT;
                  w_timer_nxt = '0;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_err = ERR_NONE;
      if (w_overflow)                    w_err = ERR_OVERFLOW;
      else if (w_underflow)              w_err = ERR_UNDERFLOW;
      else if (w_compare && w_mismatch)  w_err = ERR_MISMATCH;
      else if (w_protocol)               w_err = ERR_PROTOCOL;
      else if (w_stall)                  w_err = ERR_STALL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_pulse  <= 1'b0;
         r_err_code   <= ERR_NONE;
         r_err_sticky <= 1'b0;
         r_beat_cnt   <= '0;
         r_pkt_cnt    <= '0;
         r_err_cnt    <= '0;
      end else begin
         r_err_pulse <= (w_err != ERR_NONE);
         r_err_code  <= w_err;
         if (w_err != ERR_NONE) begin
            r_err_sticky <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
         end
         if (w_compare && !w_mismatch) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (egr_tlast) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
         end
      end
   end

   assign err_pulse  = r_err_pulse;
   assign err_code   = r_err_code;
   assign err_sticky = r_err_sticky;
   assign beat_cnt   = r_beat_cnt;
   assign pkt_cnt    = r_pkt_cnt;
   assign err_cnt    = r_err_cnt;

endmodule

// File: doc/uvmt_axis_st_stream_chkr.md
Name: uvmt_axis_st_stream_chkr

Overview:
Synthesizable end-to-end checker for the AXI-Stream self-test DUT wrapper. It captures every beat accepted on the master-side (ingress) interface into an expected-beat FIFO. It compares each beat accepted on the slave-side (egress) interface against the FIFO head. It flags data/keep/last mismatches, overflow, underflow and egress stalls, and keeps beat, packet and error counters. It is instantiated alongside the DUT wrapper in the testbench top, generalised in data width, FIFO depth and timeout.

Parameters:
DATA_W, 64, tdata width in bits; multiple of 8; keep width KEEP_W = DATA_W/8
DEPTH, 16, expected-beat FIFO entries; power of 2, >= 2
CNT_W, 32, width of beat/packet/error counters
TIMEOUT, 1024, max cycles the FIFO may be non-empty with no egress handshake; 0 disables stall check

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ing_tvalid  in  1  ingress tvalid
ing_tready  in  1  ingress tready
ing_tdata  in  DATA_W  ingress tdata
ing_tkeep  in  KEEP_W  ingress tkeep
ing_tlast  in  1  ingress tlast
egr_tvalid  in  1  egress tvalid
egr_tready  in  1  egress tready
egr_tdata  in  DATA_W  egress tdata
egr_tkeep  in  KEEP_W  egress tkeep
egr_tlast  in  1  egress tlast
err_pulse  out  1  one-cycle pulse per error event
err_code  out  3  code of the error pulsed this cycle (package enum)
err_sticky  out  1  set on first error, cleared only by reset
beat_cnt  out  CNT_W  egress beats that compared clean
pkt_cnt  out  CNT_W  clean egress beats with tlast=1
err_cnt  out  CNT_W  error events, saturating at all-ones
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is synchronous and active-high. All outputs are 0 while reset is high; the FIFO empties, the stall timer clears and the FSM goes to IDLE. A beat in flight during reset is discarded.
- Handshake: ing_hs = ing_tvalid & ing_tready; egr_hs = egr_tvalid & egr_tready. The checker is passive and never drives ready.
- Push: on ing_hs, store {tdata, tkeep, tlast}.
- Pop and compare: on egr_hs, pop the head and compare.
  - Mismatch when tkeep differs, when tlast differs, or when any byte with tkeep=1 differs. Bytes with keep=0 are ignored.
- Bypass: if the FIFO is empty and ing_hs and egr_hs occur in the same cycle, compare egress directly against ingress. Nothing is stored and nothing underflows.
- Full: ing_hs with the FIFO full and no egr_hs gives ERR_OVERFLOW and the beat is dropped. ing_hs and egr_hs together while full is legal, and the level is unchanged.
- Empty: egr_hs with the FIFO empty and no ing_hs gives ERR_UNDERFLOW. Counters other than err_cnt are not touched.
- Latency: err_pulse, err_code and the counters update 1 cycle after the handshake (registered). fifo_level is registered and reflects pushes and pops of the previous cycle.
- Counters: beat_cnt and pkt_cnt wrap at 2^CNT_W; err_cnt saturates at all-ones.
- Stall FSM (TIMEOUT>0):
  - IDLE → WAIT when the FIFO becomes non-empty; the timer clears.
  - WAIT: the timer increments each cycle without egr_hs and clears on egr_hs. On reaching TIMEOUT, go to STALLED and pulse ERR_STALL once.
  - STALLED → WAIT on egr_hs. Any state → IDLE when the FIFO is empty.
- Simultaneous errors: at most one code per cycle. Priority: OVERFLOW > UNDERFLOW > MISMATCH > PROTOCOL > STALL. err_cnt still adds 1 per cycle with any error.

Optional Feature:
UVMT_AXIS_ST_CHKR_PROTOCOL_EN:
- Defined: on both interfaces, if tvalid was 1 and tready was 0 in the previous cycle, then tvalid must remain 1 and tdata, tkeep and tlast must be unchanged. A violation gives ERR_PROTOCOL. This needs one registered copy of each interface's payload.
- Undefined: no stability registers are built, and ERR_PROTOCOL is never produced.

Decomposition:
- Package uvmt_axis_st_stream_chkr_pkg holds:
  - the err_code enum: ERR_NONE=0, ERR_MISMATCH=1, ERR_OVERFLOW=2, ERR_UNDERFLOW=3, ERR_STALL=4, ERR_PROTOCOL=5
  - the stall FSM state enum: IDLE, WAIT, STALLED
- Sub-module uvmt_axis_st_stream_chkr_fifo: synchronous FIFO of width DATA_W+KEEP_W+1, with full, empty and level outputs.

Test Plan:
- Push 0x11..0x18 (8 beats, keep=0xFF, last on 8th); egress in order 4 cycles later → beat_cnt=8, pkt_cnt=1, err_sticky=0, fifo_level returns to 0.
- Ingress 0xAABB with keep=0x03; egress 0xFFAABB with keep=0x03 → clean compare (keep=0 bytes ignored). Then egress with last flipped → err_code=1 one cycle later, err_cnt=1.
- DEPTH=16: push 17 beats with no egress → 17th gives err_code=2, fifo_level=16. Then a push and pop in the same cycle → no error, level stays 16.
- Egress beat with the FIFO empty → err_code=3. Same-cycle ingress/egress on an empty FIFO with equal data → bypass, beat_cnt+1, no error.
- TIMEOUT=8: push 1 beat, hold egr_tready=0 → single err_code=4 after 8 cycles. Egress handshake → FSM to WAIT, then IDLE.
- With UVMT_AXIS_ST_CHKR_PROTOCOL_EN: drop egr_tvalid while tready=0 → err_code=5. Assert reset mid-packet → all outputs 0 on the next cycle, fifo_level=0.
